// File: rtl/aq_djpeg_pkg.sv
// Shared codes and geometry helpers for the JPEG decoder MCU buffer.
// Sub-sampling modes, block ids and per-mode MCU geometry / legality rules.
package aq_djpeg_pkg;

  typedef enum logic [1:0] {
    SUB_400 = 2'd0,
    SUB_444 = 2'd1,
    SUB_422 = 2'd2,
    SUB_420 = 2'd3
  } sub_mode_e;

  typedef enum logic [2:0] {
    COMP_Y0 = 3'd0,
    COMP_Y1 = 3'd1,
    COMP_Y2 = 3'd2,
    COMP_Y3 = 3'd3,
    COMP_CB = 3'd4,
    COMP_CR = 3'd5
  } comp_e;

  localparam logic [5:0] BLK_LAST_ADDR = 6'd63;

  function automatic logic [4:0] mcu_w(input sub_mode_e m);
    return (m == SUB_422 || m == SUB_420) ? 5'd16 : 5'd8;
  endfunction

  function automatic logic [4:0] mcu_h(input sub_mode_e m);
    return (m == SUB_420) ? 5'd16 : 5'd8;
  endfunction

  // The block whose final sample closes an MCU.
  function automatic logic [2:0] last_comp(input sub_mode_e m);
    return (m == SUB_400) ? COMP_Y0 : COMP_CR;
  endfunction

  function automatic logic comp_legal(input sub_mode_e m, input logic [2:0] c);
    logic ok;
    case (m)
      SUB_400: ok = (c == COMP_Y0);
      SUB_444: ok = (c == COMP_Y0) || (c == COMP_CB) || (c == COMP_CR);
      SUB_422: ok = (c <= COMP_Y1) || (c == COMP_CB) || (c == COMP_CR);
      default: ok = (c <= COMP_CR);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/aq_djpeg_mcu_rdgen.sv
// Read side of the MCU buffer: raster walk over committed MCUs, RAM address
// generation and a 2-entry output skid so one pixel per cycle survives the RAM latency.
module aq_djpeg_mcu_rdgen
  import aq_djpeg_pkg::*;
#(
  parameter int  DW          = 9,
  parameter int  BANKS       = 4,
  parameter int  GRAY_CHROMA = 0,
  localparam int BW          = $clog2(BANKS),
  localparam int PW          = BW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_i,
  input  sub_mode_e     mode_i,
  input  logic [PW-1:0] wr_ptr_i,
  output logic          rd_en_o,
  output logic [BW+7:0] y_raddr_o,
  output logic [BW+5:0] c_raddr_o,
  input  logic [DW-1:0] y_rdata_i,
  input  logic [DW-1:0] cb_rdata_i,
  input  logic [DW-1:0] cr_rdata_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_y_o,
  output logic [DW-1:0] out_cb_o,
  output logic [DW-1:0] out_cr_o,
  output logic          out_last_o
);

  localparam logic [DW-1:0] GRAY = DW'(GRAY_CHROMA);

  logic [3:0]    x_q, x_d, y_q, y_d;
  logic [PW-1:0] iss_q, iss_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          infl_q, last_p_q;
  logic          wp_q, rp_q;
  logic [DW-1:0] fy_q [2];
  logic [DW-1:0] fcb_q [2];
  logic [DW-1:0] fcr_q [2];
  logic [1:0]    fl_q;

  logic [3:0]    xmax, ymax;
  logic [2:0]    occ, cx, cy;
  logic          avail, issue, iss_last, pop, push;

  // iss_q runs ahead of the release pointer so the next MCU streams without a gap.
  always_comb begin
    xmax     = 4'(mcu_w(mode_i) - 5'd1);
    ymax     = 4'(mcu_h(mode_i) - 5'd1);
    avail    = (wr_ptr_i != iss_q);
    pop      = out_valid_o & out_ready_i;
    push     = infl_q;
    occ      = {1'b0, cnt_q} + {2'b0, infl_q};
    issue    = avail && (occ < (3'd2 + {2'b0, pop}));
    iss_last = (x_q == xmax) && (y_q == ymax);
    x_d      = x_q;
    y_d      = y_q;
    iss_d    = iss_q;
    if (issue) begin
      if (x_q == xmax) begin
        x_d = 4'd0;
        if (iss_last) begin
          y_d   = 4'd0;
          iss_d = iss_q + PW'(1);
        end else begin
          y_d = y_q + 4'd1;
        end
      end else begin
        x_d = x_q + 4'd1;
      end
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_comb begin
    cx        = (mode_i == SUB_444) ? x_q[2:0] : x_q[3:1];
    cy        = (mode_i == SUB_420) ? y_q[3:1] : y_q[2:0];
    rd_en_o   = issue;
    y_raddr_o = {iss_q[BW-1:0], y_q[3], x_q[3], y_q[2:0], x_q[2:0]};
    c_raddr_o = {iss_q[BW-1:0], cy, cx};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0; y_q <= '0; iss_q <= '0; cnt_q <= '0;
      infl_q <= 1'b0; last_p_q <= 1'b0; wp_q <= 1'b0; rp_q <= 1'b0; fl_q <= '0;
      for (int i = 0; i < 2; i++) begin
        fy_q[i] <= '0; fcb_q[i] <= '0; fcr_q[i] <= '0;
      end
    end else if (init_i) begin
      x_q <= '0; y_q <= '0; iss_q <= '0; cnt_q <= '0;
      infl_q <= 1'b0; last_p_q <= 1'b0; wp_q <= 1'b0; rp_q <= 1'b0; fl_q <= '0;
      for (int i = 0; i < 2; i++) begin
        fy_q[i] <= '0; fcb_q[i] <= '0; fcr_q[i] <= '0;
      end
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      iss_q    <= iss_d;
      cnt_q    <= cnt_d;
      infl_q   <= issue;
      last_p_q <= issue & iss_last;
      if (push) begin
        fy_q[wp_q]  <= y_rdata_i;
        fcb_q[wp_q] <= (mode_i == SUB_400) ? GRAY : cb_rdata_i;
        fcr_q[wp_q] <= (mode_i == SUB_400) ? GRAY : cr_rdata_i;
        fl_q[wp_q]  <= last_p_q;
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
    end
  end

  // Handshake: a pixel transfers on out_valid_o & out_ready_i; while out_valid_o is
  // high and out_ready_i low every output holds its value.
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_y_o     = fy_q[rp_q];
  assign out_cb_o    = fcb_q[rp_q];
  assign out_cr_o    = fcr_q[rp_q];
  assign out_last_o  = fl_q[rp_q];

endmodule

// File: rtl/aq_djpeg_mcu_buf.sv
// Multi-bank MCU buffer between IDCT and colour conversion: blocks are written
// per bank, committed as whole MCUs, then streamed out as raster pixels.
module aq_djpeg_mcu_buf
  import aq_djpeg_pkg::*;
#(
  parameter int  DW          = 9,
  parameter int  BANKS       = 4,
  parameter int  GRAY_CHROMA = 0,
  localparam int BW          = $clog2(BANKS),
  localparam int PW          = BW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic [1:0]    sub_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_comp,
  input  logic [5:0]    in_addr,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_y,
  output logic [DW-1:0] out_cb,
  output logic [DW-1:0] out_cr,
  output logic          out_last,
  output logic [PW-1:0] level,
  output logic          err
);

  sub_mode_e     mode_q, mode_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          err_q, err_d;
  logic          accept, legal, wr_en, commit, release_mcu;
  logic [BW-1:0] wr_bank;

  logic [DW-1:0] y_mem  [BANKS*256];
  logic [DW-1:0] cb_mem [BANKS*64];
  logic [DW-1:0] cr_mem [BANKS*64];
  logic [DW-1:0] y_rd_q, cb_rd_q, cr_rd_q;
  logic          rd_en;
  logic [BW+7:0] y_raddr;
  logic [BW+5:0] c_raddr;

  // Pointers carry one extra bit so full (level==BANKS) and empty differ.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign in_ready = (level < PW'(BANKS));
  assign err      = err_q;
  assign wr_bank  = wr_ptr_q[BW-1:0];

  always_comb begin
    accept      = in_valid & in_ready;
    legal       = comp_legal(mode_q, in_comp);
    wr_en       = accept & legal & ~init;
    commit      = accept && legal && (in_comp == last_comp(mode_q)) && (in_addr == BLK_LAST_ADDR);
    release_mcu = out_valid & out_ready & out_last;
    mode_d      = mode_q;
    wr_ptr_d    = wr_ptr_q + PW'(commit);
    rd_ptr_d    = rd_ptr_q + PW'(release_mcu);
    err_d       = err_q | (accept & ~legal);
    if (init) begin
      mode_d   = sub_mode_e'(sub_mode);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= SUB_420;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && in_comp <= COMP_Y3) y_mem[{wr_bank, in_comp[1:0], in_addr}] <= in_data;
    if (rd_en) y_rd_q <= y_mem[y_raddr];
  end

  always_ff @(posedge clk) begin
    if (wr_en && in_comp == COMP_CB) cb_mem[{wr_bank, in_addr}] <= in_data;
    if (rd_en) cb_rd_q <= cb_mem[c_raddr];
  end

  always_ff @(posedge clk) begin
    if (wr_en && in_comp == COMP_CR) cr_mem[{wr_bank, in_addr}] <= in_data;
    if (rd_en) cr_rd_q <= cr_mem[c_raddr];
  end

  aq_djpeg_mcu_rdgen #(
    .DW          (DW),
    .BANKS       (BANKS),
    .GRAY_CHROMA (GRAY_CHROMA)
  ) u_rdgen (
    .clk         (clk),
    .rst         (rst),
    .init_i      (init),
    .mode_i      (mode_q),
    .wr_ptr_i    (wr_ptr_q),
    .rd_en_o     (rd_en),
    .y_raddr_o   (y_raddr),
    .c_raddr_o   (c_raddr),
    .y_rdata_i   (y_rd_q),
    .cb_rdata_i  (cb_rd_q),
    .cr_rdata_i  (cr_rd_q),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_y_o     (out_y),
    .out_cb_o    (out_cb),
    .out_cr_o    (out_cr),
    .out_last_o  (out_last)
  );

endmodule
